// File: rtl/cmem_arbiter_pkg.sv
// cmem_arb_pkg: shared types and helpers for the cmem arbiter.
//   arb_state_t : arbiter FSM state encoding
//   rr_pick_t   : {valid, idx} result of a round-robin pick
//   rr_encode() : rotate-and-priority-encode a request vector, starting
//                 the search just after the last granted port
package cmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Upper bound on the port count that the picker supports.
  localparam int unsigned RR_MAX_PORTS = 32;
  localparam int unsigned RR_IDX_W     = 5;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Visit ports last+1, last+2, ... (mod num_ports) and return the first
  // one that is requesting. Only the first num_ports offsets are live, so
  // the loop unrolls to a fixed mux tree for a constant num_ports.
  function automatic rr_pick_t rr_encode(input logic [RR_MAX_PORTS-1:0] req,
                                         input int unsigned num_ports,
                                         input int unsigned last);
    rr_pick_t            pick;
    logic [RR_IDX_W-1:0] cand;
    pick = '0;
    for (int unsigned ofs = 1; ofs <= RR_MAX_PORTS; ofs++) begin
      if (ofs <= num_ports) begin
        cand = RR_IDX_W'((last + ofs) % num_ports);
        if (!pick.valid && req[cand]) begin
          pick.valid = 1'b1;
          pick.idx   = cand;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cmem_arbiter_if.sv
// Bus interfaces for the cmem arbiter.
//   cmem_if : NUM_PORTS requester-side cmem ports, packed per port.
//             master = cache/requester side, slave = arbiter side.
//   pmem_if : single physical memory port.
//             master = arbiter side, slave = memory side.
interface cmem_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                   cmem_read;
  logic [NUM_PORTS-1:0]                   cmem_write;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] cmem_byte_enable;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   cmem_address;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   cmem_wdata;
  logic [NUM_PORTS-1:0]                   cmem_resp;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   cmem_rdata;

  modport master (
    output cmem_read, cmem_write, cmem_byte_enable, cmem_address, cmem_wdata,
    input  cmem_resp, cmem_rdata
  );

  modport slave (
    input  cmem_read, cmem_write, cmem_byte_enable, cmem_address, cmem_wdata,
    output cmem_resp, cmem_rdata
  );
endinterface

interface pmem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    pmem_read;
  logic                    pmem_write;
  logic [DATA_WIDTH/8-1:0] pmem_byte_enable;
  logic [ADDR_WIDTH-1:0]   pmem_address;
  logic [DATA_WIDTH-1:0]   pmem_wdata;
  logic                    pmem_resp;
  logic [DATA_WIDTH-1:0]   pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/cmem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  [NUM_PORTS]   per-port request
//   last  in  [IDX_W]       port granted most recently
//   valid out               at least one port is requesting
//   idx   out [IDX_W]       first requesting port after last, with wrap
// NUM_PORTS may not exceed cmem_arb_pkg::RR_MAX_PORTS.
import cmem_arb_pkg::*;

module rr_pick #(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  logic [RR_MAX_PORTS-1:0] req_ext;
  rr_pick_t                pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_PORTS-1:0] = req;
    pick                   = rr_encode(req_ext, NUM_PORTS, 32'(last));
  end

  assign valid = pick.valid;
  assign idx   = pick.idx[IDX_W-1:0];

  // Upper index bits are always zero for small port counts.
  logic unused_pick_idx;
  assign unused_pick_idx = ^pick.idx;

endmodule

// File: rtl/cmem_arbiter.sv
// cmem_arbiter: round-robin arbiter sharing one pmem port among NUM_PORTS
// cmem requesters. One outstanding transaction; all pmem fields come from
// registers, so no requester input reaches pmem combinationally.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmem (cmem_if.slave)     per-port read/write/be/address/wdata in,
//                            one-hot cmem_resp pulse and cmem_rdata out
//   pmem (pmem_if.master)    latched strobes and fields out, resp/rdata in
//   perf_count, perf_clear   only with CMEM_ARB_PERF_EN defined: per-port
//                            completed-transaction counters and their clear
//
// state | meaning
// IDLE  | sample requests, pick a port, latch its fields
// ISSUE | drive pmem from latched fields until pmem_resp
// RESP  | one-cycle cmem_resp pulse to the granted port
import cmem_arb_pkg::*;

module cmem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  cmem_if.slave  cmem,
  pmem_if.master pmem
`ifdef CMEM_ARB_PERF_EN
  ,
  output logic [NUM_PORTS-1:0][31:0] perf_count,
  input  logic                       perf_clear
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]  resp_q, resp_d;

  logic [NUM_PORTS-1:0]  req;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  assign req = cmem.cmem_read | cmem.cmem_write;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          grant_d = pick_idx;
          // read wins when a port raises both strobes
          rd_d    = cmem.cmem_read[pick_idx];
          wr_d    = cmem.cmem_write[pick_idx] & ~cmem.cmem_read[pick_idx];
          be_d    = cmem.cmem_byte_enable[pick_idx];
          addr_d  = cmem.cmem_address[pick_idx];
          wdata_d = cmem.cmem_wdata[pick_idx];
        end
      end
      ISSUE: begin
        if (pmem.pmem_resp) begin
          state_d         = RESP;
          rdata_d         = pmem.pmem_rdata;
          last_d          = grant_q;
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          resp_d[grant_q] = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign pmem.pmem_read        = rd_q;
  assign pmem.pmem_write       = wr_q;
  assign pmem.pmem_byte_enable = be_q;
  assign pmem.pmem_address     = addr_q;
  assign pmem.pmem_wdata       = wdata_q;
  assign cmem.cmem_resp        = resp_q;

  always_comb begin
    cmem.cmem_rdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == IDX_W'(i)) cmem.cmem_rdata[i] = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && pick_valid)
      assert (!(cmem.cmem_read[pick_idx] && cmem.cmem_write[pick_idx]));
  end

`ifdef CMEM_ARB_PERF_EN
  logic [NUM_PORTS-1:0][31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (perf_clear) perf_d = '0;
    else if (state_q == RESP) perf_d[grant_q] = perf_q[grant_q] + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_count = perf_q;
`endif

endmodule
